munoc_rdata_sequencer: RTL and testbench

//  Sequences the width-sliced AXI R-channel data buffer of a MUNOC slave interface.

---
 rtl/munoc_rdata_sequencer_pkg.sv | 34 +++
 rtl/munoc_rdata_sequencer_fifo.sv | 96 +++++++++
 rtl/munoc_rdata_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_munoc_rdata_sequencer.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/munoc_rdata_sequencer_pkg.sv
// Shared constants and helpers for the MUNOC R-data sequencer.
// Provides the AXI size codes, the sequencer FSM state encodings, the
// AR-table entry width helper and the size legality check.
package munoc_rdata_sequencer_pkg;

    // AXI ARSIZE codes the sequencer can service
    localparam logic [2:0] RSEQ_SIZE_32  = 3'b010;
    localparam logic [2:0] RSEQ_SIZE_64  = 3'b011;
    localparam logic [2:0] RSEQ_SIZE_128 = 3'b100;

    // Sequencer FSM state encodings
    localparam logic [1:0] RSEQ_IDLE   = 2'b00;
    localparam logic [1:0] RSEQ_ACTIVE = 2'b01;
    localparam logic [1:0] RSEQ_FLUSH  = 2'b10;

    // One table entry holds {bad, size, len, tid}
    function automatic int bw_rseq_entry(input int bw_tid, input int bw_len);
        return bw_tid + bw_len + 32'sd3 + 32'sd1;
    endfunction

    // A size is usable only if it is one of the supported codes and its
    // byte lanes fit inside the widest data path
    function automatic logic rseq_size_legal(input logic [2:0] size, input int bw_data);
        logic legal;
        case (size)
            RSEQ_SIZE_32:  legal = (bw_data >= 32'sd32);
            RSEQ_SIZE_64:  legal = (bw_data >= 32'sd64);
            RSEQ_SIZE_128: legal = (bw_data >= 32'sd128);
            default:       legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/munoc_rdata_sequencer_fifo.sv
// Small in-order FIFO used as the outstanding-read table.
// Ports:
//   clk_i, rstnn_i      clock, synchronous active-low reset
//   push_i, wdata_i     write an entry (ignored when full)
//   pop_i               drop the head entry (ignored when empty)
//   rdata_o             head entry (valid while !empty_o)
//   empty_o, full_o     occupancy flags
//   count_o             number of stored entries
// A pushed entry appears at the head on the following cycle; there is no
// write-to-read bypass.
module munoc_rdata_sequencer_fifo #(
    parameter int BW_DATA = 16,
    parameter int DEPTH   = 4
) (
    input  logic                         clk_i,
    input  logic                         rstnn_i,
    input  logic                         push_i,
    input  logic [BW_DATA-1:0]           wdata_i,
    input  logic                         pop_i,
    output logic [BW_DATA-1:0]           rdata_o,
    output logic                         empty_o,
    output logic                         full_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [BW_DATA-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   wptr_q, wptr_d;
    logic [PTR_W-1:0]   rptr_q, rptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               do_push_s;
    logic               do_pop_s;

    // Ring pointers wrap at DEPTH, which need not be a power of two
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] n;
        if (p == PTR_W'(DEPTH-1)) begin
            n = {PTR_W{1'b0}};
        end else begin
            n = p + PTR_W'(1);
        end
        return n;
    endfunction

    assign empty_o   = (count_q == {CNT_W{1'b0}});
    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign count_o   = count_q;
    assign rdata_o   = mem_q[rptr_q];
    assign do_push_s = push_i && !full_o;
    assign do_pop_s  = pop_i && !empty_o;

    // Next-state for pointers and occupancy
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_push_s) begin
            wptr_d = next_ptr(wptr_q);
        end else begin
            wptr_d = wptr_q;
        end
        if (do_pop_s) begin
            rptr_d = next_ptr(rptr_q);
        end else begin
            rptr_d = rptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk_i) begin
        if (!rstnn_i) begin
            wptr_q  <= {PTR_W{1'b0}};
            rptr_q  <= {PTR_W{1'b0}};
            count_q <= {CNT_W{1'b0}};
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Entry storage; contents are meaningless until pushed, so no reset
    always_ff @(posedge clk_i) begin
        if (do_push_s) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/munoc_rdata_sequencer.sv
// MUNOC slave-interface R-data sequencer.
// Records each accepted AR in an in-order table, tells the width-sliced R
// buffer which size to pop, regenerates RLAST from the recorded length and
// flushes bursts whose RLAST/RID/size disagree with the table.
// Ports:
//   clk_i, rstnn_i                      clock, synchronous active-low reset
//   ar_valid_i/ar_ready_o               AR observation / table has room
//   ar_tid_i, ar_len_i, ar_size_i       AR attributes recorded per burst
//   buf_rvalid_i, buf_rtid_i, buf_rlast_i   R buffer head beat
//   buf_rsize_o, buf_rrequest_o         lane-size code and pop to R buffer
//   m_rvalid_o, m_rready_i, m_rlast_o   master-side R handshake and RLAST
//   err_pulse_o, err_flag_o, err_clear_i    error strobe, sticky flag, clear
//   outstanding_o                       entries held in the table
module munoc_rdata_sequencer
    import munoc_rdata_sequencer_pkg::*;
#(
    parameter int BW_TID  = 4,
    parameter int BW_DATA = 128,
    parameter int BW_LEN  = 8,
    parameter int DEPTH   = 4
) (
    input  logic                         clk_i,
    input  logic                         rstnn_i,
    input  logic                         ar_valid_i,
    output logic                         ar_ready_o,
    input  logic [BW_TID-1:0]            ar_tid_i,
    input  logic [BW_LEN-1:0]            ar_len_i,
    input  logic [2:0]                   ar_size_i,
    input  logic                         buf_rvalid_i,
    input  logic [BW_TID-1:0]            buf_rtid_i,
    input  logic                         buf_rlast_i,
    output logic [2:0]                   buf_rsize_o,
    output logic                         buf_rrequest_o,
    output logic                         m_rvalid_o,
    input  logic                         m_rready_i,
    output logic                         m_rlast_o,
    output logic                         err_pulse_o,
    output logic                         err_flag_o,
    input  logic                         err_clear_i,
    output logic [$clog2(DEPTH+1)-1:0]   outstanding_o
);

    localparam int BW_ENTRY = bw_rseq_entry(BW_TID, BW_LEN);
    localparam int BW_CNT   = $clog2(DEPTH+1);

    logic [1:0]          state_q, state_d;
    logic [BW_LEN-1:0]   beat_cnt_q, beat_cnt_d;
    logic                err_pulse_q;
    logic                err_flag_q, err_flag_d;

    logic                push_s;
    logic                pop_s;
    logic [BW_ENTRY-1:0] wentry_s;
    logic [BW_ENTRY-1:0] head_s;
    logic                empty_s;
    logic                full_s;
    logic [BW_CNT-1:0]   count_s;

    logic [BW_TID-1:0]   head_tid_s;
    logic [BW_LEN-1:0]   head_len_s;
    logic [2:0]          head_size_s;
    logic                head_bad_s;
    logic                is_last_s;
    logic                last_entry_s;
    logic                mismatch_s;
    logic                m_rvalid_s;
    logic                m_rlast_s;
    logic                buf_rrequest_s;
    logic [2:0]          buf_rsize_s;

    assign ar_ready_o = !full_s;
    assign push_s     = ar_valid_i && !full_s;
    // Size legality is resolved once, at accept time
    assign wentry_s   = {!rseq_size_legal(ar_size_i, BW_DATA), ar_size_i, ar_len_i, ar_tid_i};

    munoc_rdata_sequencer_fifo #(
        .BW_DATA (BW_ENTRY),
        .DEPTH   (DEPTH)
    ) u_table (
        .clk_i   (clk_i),
        .rstnn_i (rstnn_i),
        .push_i  (push_s),
        .wdata_i (wentry_s),
        .pop_i   (pop_s),
        .rdata_o (head_s),
        .empty_o (empty_s),
        .full_o  (full_s),
        .count_o (count_s)
    );

    assign head_tid_s  = head_s[BW_TID-1:0];
    assign head_len_s  = head_s[BW_TID +: BW_LEN];
    assign head_size_s = head_s[BW_TID+BW_LEN +: 3];
    assign head_bad_s  = head_s[BW_ENTRY-1];
    assign is_last_s   = (beat_cnt_q == head_len_s);
    // Popping the only entry empties the table unless a new AR lands now
    assign last_entry_s = (count_s == BW_CNT'(1)) && !push_s;

    // FSM next-state, beat counter and R-path outputs
    always_comb begin
        state_d        = state_q;
        beat_cnt_d     = beat_cnt_q;
        pop_s          = 1'b0;
        mismatch_s     = 1'b0;
        m_rvalid_s     = 1'b0;
        m_rlast_s      = 1'b0;
        buf_rrequest_s = 1'b0;
        buf_rsize_s    = 3'b000;
        case (state_q)
            RSEQ_IDLE: begin
                if (!empty_s) begin
                    state_d = RSEQ_ACTIVE;
                end else begin
                    state_d = RSEQ_IDLE;
                end
            end
            RSEQ_ACTIVE: begin
                buf_rsize_s    = head_size_s;
                m_rlast_s      = is_last_s;
                mismatch_s     = buf_rvalid_i &&
                                 (head_bad_s || (buf_rtid_i != head_tid_s) || (buf_rlast_i != is_last_s));
                // A bad beat is never offered to the master
                m_rvalid_s     = buf_rvalid_i && !mismatch_s;
                buf_rrequest_s = m_rvalid_s && m_rready_i;
                if (mismatch_s) begin
                    state_d = RSEQ_FLUSH;
                end else if (buf_rrequest_s) begin
                    if (is_last_s) begin
                        pop_s      = 1'b1;
                        beat_cnt_d = {BW_LEN{1'b0}};
                        state_d    = last_entry_s ? RSEQ_IDLE : RSEQ_ACTIVE;
                    end else begin
                        beat_cnt_d = beat_cnt_q + BW_LEN'(1);
                    end
                end else begin
                    state_d = RSEQ_ACTIVE;
                end
            end
            RSEQ_FLUSH: begin
                // Discard beats until the slave's own RLAST closes the burst
                buf_rsize_s    = head_size_s;
                buf_rrequest_s = buf_rvalid_i;
                if (buf_rvalid_i && buf_rlast_i) begin
                    pop_s      = 1'b1;
                    beat_cnt_d = {BW_LEN{1'b0}};
                    state_d    = last_entry_s ? RSEQ_IDLE : RSEQ_ACTIVE;
                end else begin
                    state_d = RSEQ_FLUSH;
                end
            end
            default: begin
                state_d    = RSEQ_IDLE;
                beat_cnt_d = {BW_LEN{1'b0}};
            end
        endcase
    end

    // A new error takes priority over a simultaneous clear
    assign err_flag_d = mismatch_s ? 1'b1 : (err_clear_i ? 1'b0 : err_flag_q);

    // FSM and beat counter registers
    always_ff @(posedge clk_i) begin
        if (!rstnn_i) begin
            state_q    <= RSEQ_IDLE;
            beat_cnt_q <= {BW_LEN{1'b0}};
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // Error strobe and sticky flag registers
    always_ff @(posedge clk_i) begin
        if (!rstnn_i) begin
            err_pulse_q <= 1'b0;
            err_flag_q  <= 1'b0;
        end else begin
            err_pulse_q <= mismatch_s;
            err_flag_q  <= err_flag_d;
        end
    end

    assign buf_rsize_o    = buf_rsize_s;
    assign buf_rrequest_o = buf_rrequest_s;
    assign m_rvalid_o     = m_rvalid_s;
    assign m_rlast_o      = m_rlast_s;
    assign err_pulse_o    = err_pulse_q;
    assign err_flag_o     = err_flag_q;
    assign outstanding_o  = count_s;

endmodule

// File: tb/tb_munoc_rdata_sequencer.sv
// Self-checking bench for munoc_rdata_sequencer: directed scenarios plus a
// randomized phase, all checked every cycle against a transaction-level model
// (queue of recorded bursts, queue of slave beats, burst phase and beat index).
module tb_munoc_rdata_sequencer;

    localparam int BW_TID  = 4;
    localparam int BW_DATA = 128;
    localparam int BW_LEN  = 8;
    localparam int DEPTH   = 4;
    localparam int BW_CNT  = $clog2(DEPTH+1);

    localparam int PH_IDLE  = 0;
    localparam int PH_ACT   = 1;
    localparam int PH_FLUSH = 2;

    typedef struct {
        logic [BW_TID-1:0] tid;
        logic [BW_LEN-1:0] len;
        logic [2:0]        size;
        bit                bad;
    } burst_t;

    typedef struct {
        logic [BW_TID-1:0] tid;
        bit                last;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rstnn;
    logic              ar_valid;
    logic              ar_ready;
    logic [BW_TID-1:0] ar_tid;
    logic [BW_LEN-1:0] ar_len;
    logic [2:0]        ar_size;
    logic              buf_rvalid;
    logic [BW_TID-1:0] buf_rtid;
    logic              buf_rlast;
    logic [2:0]        buf_rsize;
    logic              buf_rrequest;
    logic              m_rvalid;
    logic              m_rready;
    logic              m_rlast;
    logic              err_pulse;
    logic              err_flag;
    logic              err_clear;
    logic [BW_CNT-1:0] outstanding;

    munoc_rdata_sequencer #(
        .BW_TID(BW_TID), .BW_DATA(BW_DATA), .BW_LEN(BW_LEN), .DEPTH(DEPTH)
    ) dut (
        .clk_i(clk), .rstnn_i(rstnn),
        .ar_valid_i(ar_valid), .ar_ready_o(ar_ready),
        .ar_tid_i(ar_tid), .ar_len_i(ar_len), .ar_size_i(ar_size),
        .buf_rvalid_i(buf_rvalid), .buf_rtid_i(buf_rtid), .buf_rlast_i(buf_rlast),
        .buf_rsize_o(buf_rsize), .buf_rrequest_o(buf_rrequest),
        .m_rvalid_o(m_rvalid), .m_rready_i(m_rready), .m_rlast_o(m_rlast),
        .err_pulse_o(err_pulse), .err_flag_o(err_flag), .err_clear_i(err_clear),
        .outstanding_o(outstanding)
    );

    int     n_tests = 0;
    int     n_fail  = 0;
    burst_t mq[$];
    beat_t  sq[$];
    int     phase;
    int     beat_idx;
    bit     exp_pulse;
    bit     exp_flag;
    bit     brv_allow;
    int     ckind;
    int     cidx;
    int     n_mv, n_ml, n_hs, n_err;
    logic [2:0] last_sz;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit size_ok(input logic [2:0] s);
        return (s >= 3'd2) && (s <= 3'd4) && ((8 << s) <= BW_DATA);
    endfunction

    task automatic clr_cnt();
        n_mv = 0; n_ml = 0; n_hs = 0; n_err = 0; last_sz = 3'b000;
    endtask

    // Slave beats for one accepted burst, optionally corrupted
    task automatic push_beats(input burst_t e);
        for (int i = 0; i <= int'(e.len); i++) begin
            beat_t b;
            b.tid  = e.tid;
            b.last = (i == int'(e.len));
            if (ckind == 1 && i == cidx) begin
                b.last = 1'b1;
                sq.push_back(b);
                break;
            end
            if (ckind == 2 && i == cidx) b.tid = e.tid ^ 4'h1;
            sq.push_back(b);
        end
    endtask

    // One clock: present buffer head, check every output, advance the model
    task automatic step();
        burst_t h;
        bit is_last, mism, e_mv, e_req, e_rdy, push, pop;
        logic [2:0] e_sz;
        if (brv_allow && sq.size() > 0) begin
            buf_rvalid = 1'b1; buf_rtid = sq[0].tid; buf_rlast = sq[0].last;
        end else begin
            buf_rvalid = 1'b0; buf_rtid = BW_TID'($urandom); buf_rlast = 1'($urandom);
        end
        #1;
        e_rdy = (mq.size() < DEPTH);
        is_last = 1'b0; mism = 1'b0; e_mv = 1'b0; e_req = 1'b0; e_sz = 3'b000;
        if (phase == PH_ACT) begin
            h       = mq[0];
            is_last = (beat_idx == int'(h.len));
            mism    = buf_rvalid && (h.bad || buf_rtid != h.tid || buf_rlast != is_last);
            e_mv    = buf_rvalid && !mism;
            e_req   = e_mv && m_rready;
            e_sz    = h.size;
        end else if (phase == PH_FLUSH) begin
            e_req = buf_rvalid;
        end
        chk("ar_ready", ar_ready, e_rdy);
        chk("m_rvalid", m_rvalid, e_mv);
        chk("buf_rrequest", buf_rrequest, e_req);
        chk("outstanding", outstanding, mq.size());
        chk("err_pulse", err_pulse, exp_pulse);
        chk("err_flag", err_flag, exp_flag);
        if (e_mv) chk("m_rlast", m_rlast, is_last);
        if (phase == PH_ACT) chk("buf_rsize", buf_rsize, e_sz);
        if (m_rvalid === 1'b1) begin n_mv++; last_sz = buf_rsize; end
        if (m_rvalid === 1'b1 && m_rlast === 1'b1) n_ml++;
        if (m_rvalid === 1'b1 && m_rready) n_hs++;
        if (err_pulse === 1'b1) n_err++;
        if (!rstnn) begin
            mq.delete(); sq.delete();
            phase = PH_IDLE; beat_idx = 0; exp_pulse = 1'b0; exp_flag = 1'b0;
        end else begin
            push = ar_valid && e_rdy;
            pop  = 1'b0;
            exp_pulse = mism;
            if (mism) exp_flag = 1'b1;
            else if (err_clear) exp_flag = 1'b0;
            if (phase == PH_IDLE) begin
                if (mq.size() > 0) phase = PH_ACT;
            end else if (phase == PH_ACT) begin
                if (mism) phase = PH_FLUSH;
                else if (e_req) begin
                    if (is_last) pop = 1'b1;
                    else beat_idx++;
                end
            end else begin
                if (buf_rvalid && buf_rlast) pop = 1'b1;
            end
            if (e_req) void'(sq.pop_front());
            if (pop) begin
                void'(mq.pop_front());
                beat_idx = 0;
                phase = (mq.size() > 0 || push) ? PH_ACT : PH_IDLE;
            end
            if (push) begin
                burst_t e;
                e.tid = ar_tid; e.len = ar_len; e.size = ar_size; e.bad = !size_ok(ar_size);
                mq.push_back(e);
                push_beats(e);
                ckind = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name, input int bound);
        int k = 0;
        ar_valid = 1'b0; brv_allow = 1'b1; m_rready = 1'b1;
        while (!(phase == PH_IDLE && mq.size() == 0) && k < bound) begin
            step();
            k++;
        end
        n_tests++;
        if (!(phase == PH_IDLE && mq.size() == 0)) begin
            n_fail++;
            $display("FAIL %s_drain: %0d bursts left after %0d cycles, required 0", name, mq.size(), bound);
        end
    endtask

    task automatic send_ar(input logic [BW_TID-1:0] t, input logic [BW_LEN-1:0] l, input logic [2:0] s);
        ar_valid = 1'b1; ar_tid = t; ar_len = l; ar_size = s;
        step();
        ar_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstnn = 1'b0; ar_valid = 1'b0; ar_tid = '0; ar_len = '0; ar_size = 3'b000;
        buf_rvalid = 1'b0; buf_rtid = '0; buf_rlast = 1'b0; m_rready = 1'b0; err_clear = 1'b0;
        mq.delete(); sq.delete();
        phase = PH_IDLE; beat_idx = 0; exp_pulse = 1'b0; exp_flag = 1'b0;
        brv_allow = 1'b0; ckind = 0; cidx = 0;
        clr_cnt();
        repeat (3) @(posedge clk);
        #1;
        rstnn = 1'b1;

        // Reset state
        chk("rst_ar_ready", ar_ready, 1);
        chk("rst_m_rvalid", m_rvalid, 0);
        chk("rst_buf_rrequest", buf_rrequest, 0);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_err_flag", err_flag, 0);
        chk("rst_err_pulse", err_pulse, 0);
        chk("rst_buf_rsize", buf_rsize, 0);

        // Single burst
        clr_cnt();
        send_ar(4'd3, 8'd3, 3'b100);
        chk("single_outst1", outstanding, 1);
        drain("single", 30);
        chk("single_nvalid", n_mv, 4);
        chk("single_nlast", n_ml, 1);
        chk("single_rsize", last_sz, 3'b100);
        chk("single_outst0", outstanding, 0);

        // Back-pressure for two cycles on beat 1
        begin
            int stall = 2;
            clr_cnt();
            send_ar(4'd3, 8'd3, 3'b100);
            brv_allow = 1'b1;
            for (int k = 0; k < 40 && !(phase == PH_IDLE && mq.size() == 0); k++) begin
                m_rready = !(phase == PH_ACT && beat_idx == 1 && stall > 0);
                if (!m_rready && sq.size() > 0) stall--;
                step();
            end
            drain("bp", 10);
            chk("bp_nvalid", n_mv, 6);
            chk("bp_nhs", n_hs, 4);
        end

        // Full table
        clr_cnt();
        brv_allow = 1'b0;
        ar_valid = 1'b1; ar_len = 8'd1; ar_size = 3'b011;
        for (int i = 0; i < 4; i++) begin
            ar_tid = BW_TID'(i);
            step();
        end
        ar_tid = 4'd4;
        chk("full_ar_ready0", ar_ready, 0);
        chk("full_outst4", outstanding, 4);
        brv_allow = 1'b1; m_rready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            if (ar_ready === 1'b1) break;
        end
        chk("full_ready_after_first", n_hs, 2);
        step();
        drain("full", 60);
        chk("full_total_hs", n_hs, 10);

        // Early RLAST on beat 1, then a clean burst
        clr_cnt();
        brv_allow = 1'b1; m_rready = 1'b1;
        ckind = 1; cidx = 1;
        send_ar(4'd5, 8'd3, 3'b010);
        send_ar(4'd6, 8'd1, 3'b010);
        drain("early", 40);
        chk("early_nerr", n_err, 1);
        chk("early_nhs", n_hs, 3);
        chk("early_flag", err_flag, 1);
        err_clear = 1'b1; step(); err_clear = 1'b0;
        chk("early_flag_clr", err_flag, 0);

        // Illegal size
        clr_cnt();
        send_ar(4'd7, 8'd1, 3'b101);
        drain("illegal", 30);
        chk("illegal_nhs", n_hs, 0);
        chk("illegal_nerr", n_err, 1);
        chk("illegal_flag", err_flag, 1);
        chk("illegal_outst", outstanding, 0);
        err_clear = 1'b1; step(); err_clear = 1'b0;
        chk("illegal_flag_clr", err_flag, 0);

        // Longest burst
        clr_cnt();
        send_ar(4'd9, 8'd255, 3'b011);
        drain("long", 400);
        chk("long_nhs", n_hs, 256);
        chk("long_nlast", n_ml, 1);

        // Reset mid-burst
        clr_cnt();
        send_ar(4'd2, 8'd7, 3'b100);
        brv_allow = 1'b1; m_rready = 1'b1;
        for (int k = 0; k < 30 && n_hs < 2; k++) step();
        rstnn = 1'b0; step(); rstnn = 1'b1;
        chk("rstmid_outst", outstanding, 0);
        chk("rstmid_m_rvalid", m_rvalid, 0);
        chk("rstmid_ar_ready", ar_ready, 1);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            int r;
            ar_valid  = ($urandom % 4 == 0);
            ar_tid    = BW_TID'($urandom);
            ar_len    = ($urandom % 8 == 0) ? BW_LEN'($urandom % 40) : BW_LEN'($urandom % 4);
            r         = $urandom % 10;
            ar_size   = (r == 0) ? 3'($urandom_range(5, 7)) : (r == 1) ? 3'b001 : 3'($urandom_range(2, 4));
            ckind     = 0;
            if ($urandom % 10 == 0) begin
                if (ar_len != '0 && $urandom % 2 == 0) begin
                    ckind = 1; cidx = $urandom % int'(ar_len);
                end else begin
                    ckind = 2; cidx = $urandom % (int'(ar_len) + 1);
                end
            end
            brv_allow = ($urandom % 4 != 0);
            m_rready  = ($urandom % 4 != 0);
            err_clear = ($urandom % 16 == 0);
            rstnn     = ($urandom % 700 != 0);
            step();
        end
        rstnn = 1'b1; err_clear = 1'b0; ckind = 0;
        drain("random", 2000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
